i2s_tx_frame: RTL and testbench

//  Parametrised stereo I2S/left-justified serial transmitter. Runs on the audio master clock,

---
 rtl/i2s_tx_frame_if.sv | 17 +
 rtl/i2s_tx_frame.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2s_tx_frame.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_frame_if.sv
// i2s_tx_frame_if
//   Sample handshake between a sound producer (master) and the I2S
//   transmitter (slave). One L/R pair moves when din_valid & din_ready.
//   din_l, din_r : left / right sample, DATA_WIDTH bits, two's complement
//   din_valid    : producer presents a pair
//   din_ready    : transmitter holding buffer is empty
interface i2s_tx_frame_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] din_l;
  logic [DATA_WIDTH-1:0] din_r;
  logic                  din_valid;
  logic                  din_ready;

  modport master (output din_l, output din_r, output din_valid, input din_ready);
  modport slave  (input din_l, input din_r, input din_valid, output din_ready);
endinterface

// File: rtl/i2s_tx_frame.sv
// i2s_tx_frame
//   Stereo I2S / left-justified serial transmitter. Divides bit_clk down to
//   the serial bit clock, takes L/R pairs into a one-entry holding buffer and
//   shifts them out MSB first, zero-filling slot bits beyond DATA_WIDTH.
//   A frame load with an empty buffer sends a silent frame and flags it.
// Ports
//   bit_clk     : master clock, all logic on its rising edge
//   reset_n     : asynchronous active-low reset
//   en          : 1 = transmit, 0 = idle with serial outputs parked low
//   fmt         : 0 = I2S (data lags ws by one bit), 1 = left-justified
//   din_if      : sample handshake (slave side)
//   sck/ws/sd   : serial bit clock, word select (1 = right), serial data
//   frame_start : one-cycle pulse on every frame load
//   underrun    : one-cycle pulse when a frame load found the buffer empty
module i2s_tx_frame #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 16,
  parameter int SCK_DIV    = 1
) (
  input  logic          bit_clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          fmt,
  i2s_tx_frame_if.slave din_if,
  output logic          sck,
  output logic          ws,
  output logic          sd,
  output logic          frame_start,
  output logic          underrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int CNT_W      = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
  localparam int DIV_W      = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_POS = CNT_W'(SLOT_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                state_r, state_nxt_s;
  logic [DIV_W-1:0]      div_cnt_r, div_nxt_s;
  logic [CNT_W-1:0]      bit_cnt_r, bit_nxt_s, pos_s;
  logic                  sck_r, sck_nxt_s;
  logic                  ws_r, ws_nxt_s;
  logic                  sd_r, sd_nxt_s;
  logic                  dly_r, dly_nxt_s, new_bit_s;
  logic                  fmt_r, fmt_nxt_s;
  logic [DATA_WIDTH-1:0] lat_l_r, lat_l_nxt_s, lat_r_r, lat_r_nxt_s;
  logic [DATA_WIDTH-1:0] buf_l_r, buf_l_nxt_s, buf_r_r, buf_r_nxt_s;
  logic                  buf_full_r, buf_full_nxt_s;
  logic                  din_ready_r;
  logic                  frame_start_r, frame_start_nxt_s;
  logic                  underrun_r, underrun_nxt_s;
  logic                  load_s, shift_s, acc_s;

  // Slot bit at frame position pos: MSB first, zero once the sample runs out
  // (the left shift pushes every sample bit out for positions >= DATA_WIDTH).
  function automatic logic slot_bit(input logic [CNT_W-1:0] pos,
                                    input logic [DATA_WIDTH-1:0] l,
                                    input logic [DATA_WIDTH-1:0] r);
    logic [CNT_W-1:0]      p;
    logic [DATA_WIDTH-1:0] d;
    if (pos >= SLOT_POS) begin
      p = pos - SLOT_POS;
      d = r;
    end else begin
      p = pos;
      d = l;
    end
    d = d << p;
    return d[DATA_WIDTH-1];
  endfunction

  // FSM state register
  always_ff @(posedge bit_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: en alone decides between idle and running
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en) state_nxt_s = ST_RUN;
        else    state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (en) state_nxt_s = ST_RUN;
        else    state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: divider, bit counter, serialiser and holding buffer
  always_comb begin
    div_nxt_s         = div_cnt_r;
    bit_nxt_s         = bit_cnt_r;
    sck_nxt_s         = sck_r;
    ws_nxt_s          = ws_r;
    sd_nxt_s          = sd_r;
    dly_nxt_s         = dly_r;
    fmt_nxt_s         = fmt_r;
    lat_l_nxt_s       = lat_l_r;
    lat_r_nxt_s       = lat_r_r;
    frame_start_nxt_s = 1'b0;
    underrun_nxt_s    = 1'b0;
    load_s            = 1'b0;
    shift_s           = 1'b0;
    pos_s             = bit_cnt_r;
    new_bit_s         = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // dly_r is also cleared here, so the first I2S bit after start is 0
        div_nxt_s = {DIV_W{1'b0}};
        bit_nxt_s = {CNT_W{1'b0}};
        sck_nxt_s = 1'b0;
        ws_nxt_s  = 1'b0;
        sd_nxt_s  = 1'b0;
        dly_nxt_s = 1'b0;
        if (en) begin
          fmt_nxt_s = fmt;
          load_s    = 1'b1;
        end else begin
          fmt_nxt_s = fmt_r;
        end
      end
      ST_RUN: begin
        if (!en) begin
          div_nxt_s = {DIV_W{1'b0}};
          bit_nxt_s = {CNT_W{1'b0}};
          sck_nxt_s = 1'b0;
          ws_nxt_s  = 1'b0;
          sd_nxt_s  = 1'b0;
          dly_nxt_s = 1'b0;
        end else if (div_cnt_r == DIV_LAST) begin
          div_nxt_s = {DIV_W{1'b0}};
          sck_nxt_s = ~sck_r;
          // falling sck edge advances the bit; the last bit wraps into a load
          if (sck_r) begin
            if (bit_cnt_r == CNT_LAST) load_s  = 1'b1;
            else                       shift_s = 1'b1;
          end else begin
            shift_s = 1'b0;
          end
        end else begin
          div_nxt_s = div_cnt_r + DIV_W'(1);
        end
      end
      default: begin
        div_nxt_s = {DIV_W{1'b0}};
        bit_nxt_s = {CNT_W{1'b0}};
        sck_nxt_s = 1'b0;
        ws_nxt_s  = 1'b0;
        sd_nxt_s  = 1'b0;
        dly_nxt_s = 1'b0;
      end
    endcase

    if (load_s) begin
      pos_s             = {CNT_W{1'b0}};
      frame_start_nxt_s = 1'b1;
      underrun_nxt_s    = ~buf_full_r;
      if (buf_full_r) begin
        lat_l_nxt_s = buf_l_r;
        lat_r_nxt_s = buf_r_r;
      end else begin
        lat_l_nxt_s = {DATA_WIDTH{1'b0}};
        lat_r_nxt_s = {DATA_WIDTH{1'b0}};
      end
    end else if (shift_s) begin
      pos_s = bit_cnt_r + CNT_W'(1);
    end else begin
      pos_s = bit_cnt_r;
    end

    // ws/sd change only together with a falling sck edge or a frame load
    if (load_s || shift_s) begin
      new_bit_s = slot_bit(pos_s, lat_l_nxt_s, lat_r_nxt_s);
      bit_nxt_s = pos_s;
      ws_nxt_s  = (pos_s >= SLOT_POS);
      sd_nxt_s  = fmt_nxt_s ? new_bit_s : dly_r;
      dly_nxt_s = new_bit_s;
    end else begin
      new_bit_s = 1'b0;
    end

    // A load on the accept cycle sees the buffer empty; the pair waits a frame
    acc_s = din_if.din_valid & ~buf_full_r;
    if (load_s) buf_full_nxt_s = acc_s;
    else        buf_full_nxt_s = buf_full_r | acc_s;
    if (acc_s) begin
      buf_l_nxt_s = din_if.din_l;
      buf_r_nxt_s = din_if.din_r;
    end else begin
      buf_l_nxt_s = buf_l_r;
      buf_r_nxt_s = buf_r_r;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge bit_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r     <= {DIV_W{1'b0}};
      bit_cnt_r     <= {CNT_W{1'b0}};
      sck_r         <= 1'b0;
      ws_r          <= 1'b0;
      sd_r          <= 1'b0;
      dly_r         <= 1'b0;
      fmt_r         <= 1'b0;
      lat_l_r       <= {DATA_WIDTH{1'b0}};
      lat_r_r       <= {DATA_WIDTH{1'b0}};
      buf_l_r       <= {DATA_WIDTH{1'b0}};
      buf_r_r       <= {DATA_WIDTH{1'b0}};
      buf_full_r    <= 1'b0;
      din_ready_r   <= 1'b1;
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      div_cnt_r     <= div_nxt_s;
      bit_cnt_r     <= bit_nxt_s;
      sck_r         <= sck_nxt_s;
      ws_r          <= ws_nxt_s;
      sd_r          <= sd_nxt_s;
      dly_r         <= dly_nxt_s;
      fmt_r         <= fmt_nxt_s;
      lat_l_r       <= lat_l_nxt_s;
      lat_r_r       <= lat_r_nxt_s;
      buf_l_r       <= buf_l_nxt_s;
      buf_r_r       <= buf_r_nxt_s;
      buf_full_r    <= buf_full_nxt_s;
      din_ready_r   <= ~buf_full_nxt_s;
      frame_start_r <= frame_start_nxt_s;
      underrun_r    <= underrun_nxt_s;
    end
  end

  assign sck              = sck_r;
  assign ws               = ws_r;
  assign sd               = sd_r;
  assign frame_start      = frame_start_r;
  assign underrun         = underrun_r;
  assign din_if.din_ready = din_ready_r;

endmodule

// File: tb/tb_i2s_tx_frame.sv
// tb_i2s_tx_frame
//   Directed bench. dut_a: 16-bit samples, 16-bit slots, sck = bit_clk/4.
//   dut_b: 24-bit samples in 32-bit slots, sck = bit_clk/2.
//   Serial bits are collected on sck rising edges, first bit ends up in the
//   MSB of the collected vector.
module tb_i2s_tx_frame;

  logic bit_clk;
  logic reset_n;
  logic en_a, fmt_a, sck_a, ws_a, sd_a, fs_a, ur_a;
  logic en_b, fmt_b, sck_b, ws_b, sd_b, fs_b, ur_b;

  int total = 0;
  int bad   = 0;

  i2s_tx_frame_if #(.DATA_WIDTH(16)) if_a ();
  i2s_tx_frame_if #(.DATA_WIDTH(24)) if_b ();

  i2s_tx_frame #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .SCK_DIV(2)) dut_a (
    .bit_clk(bit_clk), .reset_n(reset_n), .en(en_a), .fmt(fmt_a),
    .din_if(if_a.slave), .sck(sck_a), .ws(ws_a), .sd(sd_a),
    .frame_start(fs_a), .underrun(ur_a)
  );

  i2s_tx_frame #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .SCK_DIV(1)) dut_b (
    .bit_clk(bit_clk), .reset_n(reset_n), .en(en_b), .fmt(fmt_b),
    .din_if(if_b.slave), .sck(sck_b), .ws(ws_b), .sd(sd_b),
    .frame_start(fs_b), .underrun(ur_b)
  );

  initial bit_clk = 1'b0;
  always #5 bit_clk = ~bit_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next frame_start; returns negedges waited and underrun.
  task automatic wait_fs(input int which, output int cyc, output logic ur);
    logic hit;
    hit = 1'b0;
    cyc = 0;
    ur  = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge bit_clk);
      cyc++;
      if (((which == 0) ? fs_a : fs_b) === 1'b1) begin
        hit = 1'b1;
        ur  = (which == 0) ? ur_a : ur_b;
      end
    end
    if (!hit) chk("frame_start_timeout", 64'(hit), 64'd1);
  endtask

  // Collect n bits of ws/sd on sck rising edges.
  task automatic capture(input int which, input int n,
                         output logic [63:0] wsv, output logic [63:0] sdv);
    logic prev, cur;
    int   got;
    got  = 0;
    wsv  = 64'd0;
    sdv  = 64'd0;
    prev = (which == 0) ? sck_a : sck_b;
    for (int i = 0; i < 1000 && got < n; i++) begin
      @(negedge bit_clk);
      cur = (which == 0) ? sck_a : sck_b;
      if (cur && !prev) begin
        wsv = {wsv[62:0], ((which == 0) ? ws_a : ws_b)};
        sdv = {sdv[62:0], ((which == 0) ? sd_a : sd_b)};
        got++;
      end
      prev = cur;
    end
    if (got != n) chk("capture_timeout", 64'(got), 64'(n));
  endtask

  // Present one pair from a negedge, hold until accepted, then drop valid.
  task automatic push(input int which, input logic [23:0] l, input logic [23:0] r);
    if (which == 0) begin
      if_a.din_l = l[15:0];
      if_a.din_r = r[15:0];
      if_a.din_valid = 1'b1;
      for (int i = 0; i < 300 && if_a.din_ready !== 1'b1; i++) @(negedge bit_clk);
      chk("push_ready_a", 64'(if_a.din_ready), 64'd1);
      @(negedge bit_clk);
      if_a.din_valid = 1'b0;
    end else begin
      if_b.din_l = l;
      if_b.din_r = r;
      if_b.din_valid = 1'b1;
      for (int i = 0; i < 300 && if_b.din_ready !== 1'b1; i++) @(negedge bit_clk);
      chk("push_ready_b", 64'(if_b.din_ready), 64'd1);
      @(negedge bit_clk);
      if_b.din_valid = 1'b0;
    end
  endtask

  initial begin
    int          cyc;
    logic        ur;
    logic [63:0] wsv, sdv;
    logic        pend;
    int          seq, n_fs, n_ur, n_acc, n_rdy;
    logic [15:0] last_l, last_r;

    reset_n = 1'b1;
    en_a = 1'b0; fmt_a = 1'b0; en_b = 1'b0; fmt_b = 1'b0;
    if_a.din_valid = 1'b0; if_a.din_l = 16'h0000; if_a.din_r = 16'h0000;
    if_b.din_valid = 1'b0; if_b.din_l = 24'h000000; if_b.din_r = 24'h000000;
    last_l = 16'h0000; last_r = 16'h0000;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_state", {sck_a, ws_a, sd_a, fs_a, ur_a, if_a.din_ready}, 6'b000001);
    repeat (3) @(negedge bit_clk);
    reset_n = 1'b1;
    @(negedge bit_clk);

    // 24-bit samples in 32-bit slots, left-justified, buffer full at start
    fmt_b = 1'b1;
    push(1, 24'h800001, 24'h00F00F);
    en_b = 1'b1;
    wait_fs(1, cyc, ur);
    chk("b_first_load_cyc", 64'(cyc), 64'd1);
    chk("b_first_ur", 64'(ur), 64'd0);
    capture(1, 64, wsv, sdv);
    chk("b_ws", wsv, 64'h0000_0000_FFFF_FFFF);
    chk("b_sd", sdv, 64'h8000_0100_00F0_0F00);
    wait_fs(1, cyc, ur);
    chk("b_ur_empty", 64'(ur), 64'd1);
    wait_fs(1, cyc, ur);
    chk("b_period", 64'(cyc), 64'd128);
    en_b = 1'b0;

    // I2S: start and accept on the same cycle -> silent first frame
    fmt_a = 1'b0;
    en_a  = 1'b1;
    if_a.din_l = 16'hA5F0; if_a.din_r = 16'h0F0F; if_a.din_valid = 1'b1;
    @(negedge bit_clk);
    if_a.din_valid = 1'b0;
    chk("i2s_start_fs_ur", {fs_a, ur_a}, 2'b11);
    chk("i2s_start_ready", 64'(if_a.din_ready), 64'd0);
    capture(0, 32, wsv, sdv);
    chk("i2s_f1_ws", wsv, 64'h0000_FFFF);
    chk("i2s_f1_sd", sdv, 64'h0);
    wait_fs(0, cyc, ur);
    chk("i2s_f2_ur", 64'(ur), 64'd0);
    capture(0, 32, wsv, sdv);
    chk("i2s_f2_ws", wsv, 64'h0000_FFFF);
    chk("i2s_f2_sd", sdv, 64'h52F8_0787);
    wait_fs(0, cyc, ur);
    chk("i2s_f3_ur", 64'(ur), 64'd1);
    capture(0, 32, wsv, sdv);
    chk("i2s_f3_spill", sdv, 64'h8000_0000);
    wait_fs(0, cyc, ur);
    wait_fs(0, cyc, ur);
    chk("i2s_period", 64'(cyc), 64'd128);

    // Left-justified, same data, buffer full at idle->run
    en_a = 1'b0;
    @(negedge bit_clk);
    chk("idle_park", {sck_a, ws_a, sd_a}, 3'b000);
    fmt_a = 1'b1;
    push(0, 24'h00A5F0, 24'h000F0F);
    en_a = 1'b1;
    wait_fs(0, cyc, ur);
    chk("lj_load_cyc", 64'(cyc), 64'd1);
    chk("lj_ur", 64'(ur), 64'd0);
    capture(0, 32, wsv, sdv);
    chk("lj_ws", wsv, 64'h0000_FFFF);
    chk("lj_sd", sdv, 64'hA5F0_0F0F);

    // Continuous feed: one pair per frame, no underrun
    seq = 0;
    n_fs = 0; n_ur = 0; n_acc = 0; n_rdy = 0;
    if_a.din_l = 16'h1000; if_a.din_r = 16'h2000; if_a.din_valid = 1'b1;
    pend = if_a.din_ready;
    for (int c = 0; c < 1100; c++) begin
      @(negedge bit_clk);
      if (pend) begin
        if (c >= 200 && c < 712) n_acc++;
        last_l = if_a.din_l;
        last_r = if_a.din_r;
        seq++;
        if_a.din_l = 16'h1000 + 16'(seq);
        if_a.din_r = 16'h2000 + 16'(seq);
      end
      pend = if_a.din_ready;
      if (c >= 200 && c < 712) begin
        if (fs_a) n_fs++;
        if (ur_a) n_ur++;
        if (if_a.din_ready) n_rdy++;
      end
      if (c >= 712 && !if_a.din_ready) break;
    end
    if_a.din_valid = 1'b0;
    chk("feed_frames", 64'(n_fs), 64'd4);
    chk("feed_underruns", 64'(n_ur), 64'd0);
    chk("feed_accepts", 64'(n_acc), 64'd4);
    chk("feed_ready_cycles", 64'(n_rdy), 64'd4);

    // Stop feeding: the buffered pair goes out, then silent frames
    wait_fs(0, cyc, ur);
    chk("drain_ur", 64'(ur), 64'd0);
    capture(0, 32, wsv, sdv);
    chk("drain_sd", sdv, {32'h0, last_l, last_r});
    wait_fs(0, cyc, ur);
    chk("starve_ur1", 64'(ur), 64'd1);
    wait_fs(0, cyc, ur);
    chk("starve_ur2", 64'(ur), 64'd1);
    chk("starve_period", 64'(cyc), 64'd128);
    // Accept exactly on the load edge
    repeat (127) @(negedge bit_clk);
    if_a.din_l = 16'h1234; if_a.din_r = 16'hFEDC; if_a.din_valid = 1'b1;
    @(negedge bit_clk);
    if_a.din_valid = 1'b0;
    chk("load_accept_fs_ur", {fs_a, ur_a}, 2'b11);
    chk("load_accept_ready", 64'(if_a.din_ready), 64'd0);
    wait_fs(0, cyc, ur);
    chk("load_accept_next_ur", 64'(ur), 64'd0);
    capture(0, 32, wsv, sdv);
    chk("load_accept_sd", sdv, 64'h1234_FEDC);

    // Asynchronous reset in the right slot with a full buffer
    wait_fs(0, cyc, ur);
    push(0, 24'h005555, 24'h00AAAA);
    repeat (78) @(negedge bit_clk);
    chk("pre_reset_ws", 64'(ws_a), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_out", {sck_a, ws_a, sd_a, if_a.din_ready}, 4'b0001);
    en_a = 1'b0;
    @(negedge bit_clk);
    reset_n = 1'b1;
    @(negedge bit_clk);
    fmt_a = 1'b1;
    en_a  = 1'b1;
    wait_fs(0, cyc, ur);
    chk("reset_discard_ur", 64'(ur), 64'd1);

    // en dropped mid-frame: outputs park, buffered pair survives
    push(0, 24'h00CAFE, 24'h000BAD);
    repeat (40) @(negedge bit_clk);
    en_a = 1'b0;
    @(negedge bit_clk);
    chk("pause_park", {sck_a, ws_a, sd_a, if_a.din_ready}, 4'b0000);
    repeat (3) @(negedge bit_clk);
    en_a = 1'b1;
    wait_fs(0, cyc, ur);
    chk("resume_cyc", 64'(cyc), 64'd1);
    chk("resume_ur", 64'(ur), 64'd0);
    capture(0, 32, wsv, sdv);
    chk("resume_sd", sdv, 64'hCAFE_0BAD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
